// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Two-requester front end for a single shared ALU. At most one operation is
//   outstanding. A request is captured, issued to the ALU, and the ALU result
//   is held for the requester that owns it until that requester takes it.
//   On a tie the requester that did not complete last wins.
//
// Ports
//   clk, rst_n                     clock, async active-low reset
//   i_reqN_{a,b,op,signed,valid}   requester N operands + request valid (N=0,1)
//   o_reqN_ready                   request accept, only in IDLE for the granted side
//   o_resN_{result,error,valid}    result to requester N, i_resN_ready takes it
//   o_alu_input_*                  registered operands toward the ALU
//   i_alu_result*, o_alu_result_ready  ALU result handshake
//   i_abort                        cancel the in-flight operation
//   o_busy, o_owner                not-IDLE flag, index of the current owner
module alu_arbiter #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] i_req0_a,
  input  logic [DATA_WIDTH-1:0] i_req0_b,
  input  logic [1:0]            i_req0_op,
  input  logic                  i_req0_signed,
  input  logic                  i_req0_valid,
  output logic                  o_req0_ready,
  input  logic [DATA_WIDTH-1:0] i_req1_a,
  input  logic [DATA_WIDTH-1:0] i_req1_b,
  input  logic [1:0]            i_req1_op,
  input  logic                  i_req1_signed,
  input  logic                  i_req1_valid,
  output logic                  o_req1_ready,
  output logic [DATA_WIDTH-1:0] o_res0_result,
  output logic                  o_res0_error,
  output logic                  o_res0_valid,
  input  logic                  i_res0_ready,
  output logic [DATA_WIDTH-1:0] o_res1_result,
  output logic                  o_res1_error,
  output logic                  o_res1_valid,
  input  logic                  i_res1_ready,
  output logic [DATA_WIDTH-1:0] o_alu_input_a,
  output logic [DATA_WIDTH-1:0] o_alu_input_b,
  output logic [1:0]            o_alu_input_op,
  output logic                  o_alu_input_signed,
  output logic                  o_alu_input_valid,
  input  logic                  i_alu_input_ready,
  input  logic [DATA_WIDTH-1:0] i_alu_result,
  input  logic                  i_alu_error,
  input  logic                  i_alu_result_valid,
  output logic                  o_alu_result_ready,
  input  logic                  i_abort,
  output logic                  o_busy,
  output logic                  o_owner
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RETURN, DRAIN} state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic [1:0]            op;
    logic                  sgn;
  } req_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] result;
    logic                  error;
  } rsp_t;

  state_t     state, state_nxt;
  req_t       req_q, req_d;
  rsp_t       rsp_q, rsp_d;
  logic       owner_q, owner_d;
  logic       last_q, last_d;
  req_t [1:0] req_in;
  logic [1:0] req_vld, req_rdy, res_rdy, res_vld;
  logic       grant, alu_in_vld, alu_res_rdy;

  assign req_in[0] = '{a: i_req0_a, b: i_req0_b, op: i_req0_op, sgn: i_req0_signed};
  assign req_in[1] = '{a: i_req1_a, b: i_req1_b, op: i_req1_op, sgn: i_req1_signed};
  assign req_vld   = {i_req1_valid, i_req0_valid};
  assign res_rdy   = {i_res1_ready, i_res0_ready};

  // Sole requester wins; on a tie the side that did not complete last wins.
  assign grant = (&req_vld) ? ~last_q : req_vld[1];

  always_comb begin
    state_nxt   = state;
    req_d       = req_q;
    rsp_d       = rsp_q;
    owner_d     = owner_q;
    last_d      = last_q;
    req_rdy     = '0;
    res_vld     = '0;
    alu_in_vld  = 1'b0;
    alu_res_rdy = 1'b0;
    case (state)
      IDLE: begin
        // Abort is ignored here; the grant still goes through.
        if (|req_vld) begin
          req_rdy[grant] = 1'b1;
          req_d          = req_in[grant];
          owner_d        = grant;
          state_nxt      = ISSUE;
        end
      end
      ISSUE: begin
        alu_in_vld = 1'b1;
        // A handshake in the abort cycle means the ALU owns the op: drain it.
        if (i_alu_input_ready) state_nxt = i_abort ? DRAIN : WAIT;
        else if (i_abort)      state_nxt = IDLE;
      end
      WAIT: begin
        alu_res_rdy = 1'b1;
        if (i_abort) begin
          state_nxt = i_alu_result_valid ? IDLE : DRAIN;
        end else if (i_alu_result_valid) begin
          rsp_d     = '{result: i_alu_result, error: i_alu_error};
          state_nxt = RETURN;
        end
      end
      RETURN: begin
        // Abort masks the valid so a result is never seen as delivered.
        if (i_abort) begin
          state_nxt = IDLE;
        end else begin
          res_vld[owner_q] = 1'b1;
          if (res_rdy[owner_q]) begin
            last_d    = owner_q;
            state_nxt = IDLE;
          end
        end
      end
      DRAIN: begin
        alu_res_rdy = 1'b1;
        if (i_alu_result_valid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      req_q   <= '0;
      rsp_q   <= '0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state   <= state_nxt;
      req_q   <= req_d;
      rsp_q   <= rsp_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  assign o_req0_ready       = req_rdy[0];
  assign o_req1_ready       = req_rdy[1];
  assign o_alu_input_a      = req_q.a;
  assign o_alu_input_b      = req_q.b;
  assign o_alu_input_op     = req_q.op;
  assign o_alu_input_signed = req_q.sgn;
  assign o_alu_input_valid  = alu_in_vld;
  assign o_alu_result_ready = alu_res_rdy;
  assign o_res0_result      = rsp_q.result;
  assign o_res0_error       = rsp_q.error;
  assign o_res0_valid       = res_vld[0];
  assign o_res1_result      = rsp_q.result;
  assign o_res1_error       = rsp_q.error;
  assign o_res1_valid       = res_vld[1];
  assign o_busy             = (state != IDLE);
  assign o_owner            = owner_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: the bench plays both requesters and the ALU.
// Inputs are driven on the falling edge and outputs sampled 1 time unit later.
module tb_alu_arbiter;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0]   req0_op, req1_op;
  logic         req0_sgn, req1_sgn, req0_valid, req1_valid, req0_ready, req1_ready;
  logic [W-1:0] res0_result, res1_result;
  logic         res0_error, res1_error, res0_valid, res1_valid, res0_ready, res1_ready;
  logic [W-1:0] alu_a, alu_b, alu_result;
  logic [1:0]   alu_op;
  logic         alu_sgn, alu_in_valid, alu_in_ready, alu_error, alu_result_valid, alu_result_ready;
  logic         abort, busy, owner;

  int n_tests = 0;
  int n_fail  = 0;
  bit lg_m;   // model: requester that completed most recently

  alu_arbiter #(.DATA_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req0_a(req0_a), .i_req0_b(req0_b), .i_req0_op(req0_op), .i_req0_signed(req0_sgn),
    .i_req0_valid(req0_valid), .o_req0_ready(req0_ready),
    .i_req1_a(req1_a), .i_req1_b(req1_b), .i_req1_op(req1_op), .i_req1_signed(req1_sgn),
    .i_req1_valid(req1_valid), .o_req1_ready(req1_ready),
    .o_res0_result(res0_result), .o_res0_error(res0_error), .o_res0_valid(res0_valid),
    .i_res0_ready(res0_ready),
    .o_res1_result(res1_result), .o_res1_error(res1_error), .o_res1_valid(res1_valid),
    .i_res1_ready(res1_ready),
    .o_alu_input_a(alu_a), .o_alu_input_b(alu_b), .o_alu_input_op(alu_op),
    .o_alu_input_signed(alu_sgn), .o_alu_input_valid(alu_in_valid), .i_alu_input_ready(alu_in_ready),
    .i_alu_result(alu_result), .i_alu_error(alu_error), .i_alu_result_valid(alu_result_valid),
    .o_alu_result_ready(alu_result_ready),
    .i_abort(abort), .o_busy(busy), .o_owner(owner)
  );

  // Handshake signature: req0_rdy req1_rdy alu_in_vld alu_res_rdy res0_vld res1_vld busy
  function automatic logic [6:0] sig();
    return {req0_ready, req1_ready, alu_in_valid, alu_result_ready, res0_valid, res1_valid, busy};
  endfunction

  // Round-robin rule: a lone requester wins, a tie goes to the one that did not finish last.
  function automatic bit pick(bit v0, bit v1);
    if (v0 && v1) return ~lg_m;
    return v1;
  endfunction

  // One complete transaction with chosen stall lengths at each handshake.
  task automatic run_txn(input bit v0, input bit v1, input bit hold,
                         input logic [W-1:0] a0, input logic [W-1:0] b0, input logic [1:0] op0, input bit s0,
                         input logic [W-1:0] a1, input logic [W-1:0] b1, input logic [1:0] op1, input bit s1,
                         input int d_iss, input int d_wait, input int d_ret,
                         input logic [W-1:0] res, input bit err, output bit own);
    logic [2*W+2:0] exp_ops;
    logic [W:0]     got_rsp;
    bit             nx;
    own     = pick(v0, v1);
    exp_ops = own ? {a1, b1, op1, s1} : {a0, b0, op0, s0};
    req0_a = a0; req0_b = b0; req0_op = op0; req0_sgn = s0; req0_valid = v0;
    req1_a = a1; req1_b = b1; req1_op = op1; req1_sgn = s1; req1_valid = v1;
    #1;
    if (sig() !== {!own, own, 5'b0}) begin
      n_fail++; $display("FAIL grant: sig=%b want %b", sig(), {!own, own, 5'b0});
    end
    n_tests++;
    @(negedge clk);
    if (!hold) begin req0_valid = 1'b0; req1_valid = 1'b0; end
    // Disturb requester inputs so any pass-through instead of capture shows up.
    req0_a = ~a0; req0_op = ~op0; req1_b = ~b1; req1_sgn = ~s1;
    for (int i = 0; i <= d_iss; i++) begin
      alu_in_ready = (i == d_iss);
      #1;
      if (sig() !== 7'b0010001 || {alu_a, alu_b, alu_op, alu_sgn} !== exp_ops || owner !== own) begin
        n_fail++;
        $display("FAIL issue[%0d]: sig=%b ops=%h owner=%b want sig=0010001 ops=%h owner=%b",
                 i, sig(), {alu_a, alu_b, alu_op, alu_sgn}, owner, exp_ops, own);
      end
      n_tests++;
      @(negedge clk);
    end
    alu_in_ready = 1'b0;
    for (int i = 0; i <= d_wait; i++) begin
      alu_result_valid = (i == d_wait); alu_result = res; alu_error = err;
      #1;
      if (sig() !== 7'b0001001) begin
        n_fail++; $display("FAIL wait[%0d]: sig=%b want 0001001", i, sig());
      end
      n_tests++;
      @(negedge clk);
    end
    alu_result_valid = 1'b0; alu_result = ~res; alu_error = ~err;
    for (int i = 0; i <= d_ret; i++) begin
      res0_ready = !own && (i == d_ret);
      res1_ready = own && (i == d_ret);
      #1;
      got_rsp = own ? {res1_result, res1_error} : {res0_result, res0_error};
      if (sig() !== {4'b0000, !own, own, 1'b1} || got_rsp !== {res, err}) begin
        n_fail++;
        $display("FAIL return[%0d]: sig=%b rsp=%h want sig=%b rsp=%h",
                 i, sig(), got_rsp, {4'b0000, !own, own, 1'b1}, {res, err});
      end
      n_tests++;
      @(negedge clk);
    end
    res0_ready = 1'b0; res1_ready = 1'b0;
    lg_m = own;
    nx = pick(req0_valid, req1_valid);
    #1;
    if (sig() !== {req0_valid && !nx, req1_valid && nx, 5'b0}) begin
      n_fail++;
      $display("FAIL back_to_idle: sig=%b want %b", sig(), {req0_valid && !nx, req1_valid && nx, 5'b0});
    end
    n_tests++;
  endtask

  // Accept a single request from requester r; leaves the DUT in ISSUE.
  task automatic enter_issue(input bit r);
    if (r) begin
      req1_a = W'($urandom); req1_b = W'($urandom); req1_op = 2'($urandom); req1_valid = 1'b1;
    end else begin
      req0_a = W'($urandom); req0_b = W'($urandom); req0_op = 2'($urandom); req0_valid = 1'b1;
    end
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  // Accept and issue; leaves the DUT in WAIT.
  task automatic enter_wait(input bit r);
    enter_issue(r);
    alu_in_ready = 1'b1;
    @(negedge clk);
    alu_in_ready = 1'b0;
  endtask

  task automatic test_reset();
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk); @(negedge clk);
    #1;
    if (sig() !== 7'b1000000 || owner !== 1'b0) begin
      n_fail++; $display("FAIL reset_ctrl: sig=%b owner=%b want 1000000 0", sig(), owner);
    end
    n_tests++;
    if ({alu_a, alu_b, alu_op, alu_sgn} !== '0 || {res0_result, res0_error} !== '0) begin
      n_fail++; $display("FAIL reset_data: alu=%h res=%h want 0", {alu_a, alu_b}, res0_result);
    end
    n_tests++;
    rst_n = 1'b1;
    lg_m  = 1'b1;
  endtask

  // Both requesters kept valid straight out of reset: 0, 1, 0.
  task automatic test_alternation();
    bit own;
    bit [2:0] seq;
    for (int k = 0; k < 3; k++) begin
      run_txn(1'b1, 1'b1, 1'b1, W'(k + 1), W'(k + 2), 2'(k), 1'b0, W'(k + 10), W'(k + 20), 2'(k + 1), 1'b1,
              0, 0, 0, W'(100 + k), 1'b0, own);
      seq[k] = own;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    if (seq !== 3'b010) begin
      n_fail++; $display("FAIL alternation: owners(k2..k0)=%b want 010", seq);
    end
    n_tests++;
    @(negedge clk);
  endtask

  task automatic test_basic();
    bit own;
    run_txn(1'b1, 1'b0, 1'b0, 16'd7, 16'd5, 2'd0, 1'b0, 16'd0, 16'd0, 2'd0, 1'b0,
            0, 1, 0, 16'd12, 1'b0, own);
    @(negedge clk);
  endtask

  task automatic test_stall();
    bit own;
    req0_valid = 1'b1; req1_valid = 1'b1;
    run_txn(1'b1, 1'b1, 1'b0, 16'h1234, 16'h5678, 2'd2, 1'b1, 16'h9abc, 16'hdef0, 2'd3, 1'b0,
            5, 0, 0, 16'h0f0f, 1'b0, own);
    @(negedge clk);
  endtask

  task automatic test_error_backpressure();
    bit own;
    run_txn(1'b0, 1'b1, 1'b0, 16'h0, 16'h0, 2'd0, 1'b0, 16'hffff, 16'h0001, 2'd1, 1'b1,
            0, 0, 3, 16'h0000, 1'b1, own);
    @(negedge clk);
  endtask

  task automatic test_abort();
    bit exp_g;
    // ISSUE abort without an ALU handshake: operation dropped.
    enter_issue(1'b0);
    abort = 1'b1;
    #1;
    if (busy !== 1'b1 || {res0_valid, res1_valid, alu_result_ready} !== 3'b000) begin
      n_fail++; $display("FAIL abort_issue_cycle: sig=%b", sig());
    end
    n_tests++;
    @(negedge clk);
    abort = 1'b0;
    #1;
    if (sig() !== 7'b0) begin n_fail++; $display("FAIL abort_issue: sig=%b want 0000000", sig()); end
    n_tests++;
    // ISSUE abort coinciding with the ALU handshake: result must be drained.
    @(negedge clk);
    enter_issue(1'b1);
    abort = 1'b1; alu_in_ready = 1'b1;
    @(negedge clk);
    abort = 1'b0; alu_in_ready = 1'b0;
    #1;
    if (sig() !== 7'b0001001) begin n_fail++; $display("FAIL drain_enter: sig=%b want 0001001", sig()); end
    n_tests++;
    @(negedge clk);
    alu_result_valid = 1'b1; alu_result = W'($urandom);
    @(negedge clk);
    alu_result_valid = 1'b0;
    #1;
    if (sig() !== 7'b0) begin n_fail++; $display("FAIL drain_exit: sig=%b want 0000000", sig()); end
    n_tests++;
    // WAIT abort, ALU result arrives two cycles later.
    @(negedge clk);
    enter_wait(1'b0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    for (int i = 0; i < 2; i++) begin
      alu_result_valid = (i == 1); alu_result = 16'hbeef;
      #1;
      if (sig() !== 7'b0001001) begin n_fail++; $display("FAIL drain_hold[%0d]: sig=%b want 0001001", i, sig()); end
      n_tests++;
      @(negedge clk);
    end
    alu_result_valid = 1'b0;
    #1;
    if (sig() !== 7'b0) begin n_fail++; $display("FAIL drain_done: sig=%b want 0000000", sig()); end
    n_tests++;
    // WAIT abort with the result in the same cycle: straight to IDLE.
    @(negedge clk);
    enter_wait(1'b1);
    abort = 1'b1; alu_result_valid = 1'b1;
    @(negedge clk);
    abort = 1'b0; alu_result_valid = 1'b0;
    #1;
    if (sig() !== 7'b0) begin n_fail++; $display("FAIL wait_abort_result: sig=%b want 0000000", sig()); end
    n_tests++;
    // RETURN abort: valid masked immediately, no delivery.
    @(negedge clk);
    enter_wait(1'b0);
    alu_result_valid = 1'b1; alu_result = 16'h5a5a;
    @(negedge clk);
    alu_result_valid = 1'b0;
    abort = 1'b1; res0_ready = 1'b1;
    #1;
    if (sig() !== 7'b0000001) begin n_fail++; $display("FAIL ret_abort: sig=%b want 0000001", sig()); end
    n_tests++;
    @(negedge clk);
    abort = 1'b0; res0_ready = 1'b0;
    #1;
    if (sig() !== 7'b0) begin n_fail++; $display("FAIL ret_exit: sig=%b want 0000000", sig()); end
    n_tests++;
    // No aborted op may have moved the tie-break.
    exp_g = pick(1'b1, 1'b1);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    if (sig() !== {!exp_g, exp_g, 5'b0}) begin
      n_fail++; $display("FAIL lg_kept: sig=%b want %b", sig(), {!exp_g, exp_g, 5'b0});
    end
    n_tests++;
    // Abort in IDLE does not block the grant.
    abort = 1'b1;
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    if ({busy, owner, alu_in_valid} !== {1'b1, exp_g, 1'b1}) begin
      n_fail++; $display("FAIL idle_abort: busy/owner/alu_vld=%b want %b", {busy, owner, alu_in_valid}, {1'b1, exp_g, 1'b1});
    end
    n_tests++;
    @(negedge clk);   // abort still high in ISSUE -> back to IDLE
    abort = 1'b0;
    #1;
    if (sig() !== 7'b0) begin n_fail++; $display("FAIL abort_cleanup: sig=%b want 0000000", sig()); end
    n_tests++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit own;
    enter_wait(1'b1);
    #3 rst_n = 1'b0;
    #1;
    if (sig() !== 7'b0 || owner !== 1'b0) begin
      n_fail++; $display("FAIL rst_async: sig=%b owner=%b want 0000000 0", sig(), owner);
    end
    n_tests++;
    @(negedge clk);
    rst_n = 1'b1;
    lg_m  = 1'b1;
    alu_result_valid = 1'b1; alu_result = 16'hdead;
    #1;
    if (sig() !== 7'b0) begin n_fail++; $display("FAIL stray_result: sig=%b want 0000000", sig()); end
    n_tests++;
    @(negedge clk);
    alu_result_valid = 1'b0;
    #1;
    if (sig() !== 7'b0) begin n_fail++; $display("FAIL stray_ignored: sig=%b want 0000000", sig()); end
    n_tests++;
    run_txn(1'b1, 1'b0, 1'b0, 16'h0102, 16'h0304, 2'd3, 1'b1, 16'h0, 16'h0, 2'd0, 1'b0,
            1, 1, 1, 16'h0406, 1'b0, own);
    @(negedge clk);
  endtask

  task automatic test_random();
    bit own;
    logic [1:0] v;
    for (int k = 0; k < 30; k++) begin
      v = 2'($urandom_range(1, 3));
      run_txn(v[0], v[1], 1'($urandom),
              W'($urandom), W'($urandom), 2'($urandom), 1'($urandom),
              W'($urandom), W'($urandom), 2'($urandom), 1'($urandom),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              W'($urandom), 1'($urandom), own);
      req0_valid = 1'b0; req1_valid = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    {req0_a, req0_b, req0_op, req0_sgn, req0_valid} = '0;
    {req1_a, req1_b, req1_op, req1_sgn, req1_valid} = '0;
    {res0_ready, res1_ready, alu_in_ready, alu_result_valid, alu_error, abort} = '0;
    alu_result = '0;
    lg_m = 1'b1;
    test_reset();
    test_alternation();
    test_basic();
    test_stall();
    test_error_backpressure();
    test_abort();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
